// File: rtl/parking_gate_pkg.sv
// parking_gate_pkg: shared types and defaults for the parking gate controller.
//   state_e    - lane FSM state encoding (2 bits)
//   DEF_*      - default parameter values
//   cnt_width  - bits needed to hold the values 0..n
package parking_gate_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_KEY = 2'd1,
    OPEN     = 2'd2,
    LOCKED   = 2'd3
  } state_e;

  localparam int DEF_PSWD_W       = 8;
  localparam int DEF_PSWD_VAL     = 253;
  localparam int DEF_MAX_TRIES    = 3;
  localparam int DEF_LOCK_CYCLES  = 64;
  localparam int DEF_OPEN_TIMEOUT = 32;
  localparam int DEF_CAPACITY     = 8;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/parking_gate_if.sv
// parking_gate_if: lane signal bundle between sensors/keypad and the gate controller.
//   car, fr_sens, bk_sens, ex_sens, pswd, pswd_vld : sensor/keypad inputs to the controller
//   gate, locked, full, occ                       : controller outputs
//   alarm                                         : only when PARKING_GATE_ALARM_EN is defined
// Modports: master = lane side (drives sensors), slave = controller.
interface parking_gate_if
  import parking_gate_pkg::*;
#(
  parameter int PSWD_W   = DEF_PSWD_W,
  parameter int CAPACITY = DEF_CAPACITY
);
  localparam int OCC_W = cnt_width(CAPACITY);

  logic              car;
  logic              fr_sens;
  logic              bk_sens;
  logic              ex_sens;
  logic [PSWD_W-1:0] pswd;
  logic              pswd_vld;
  logic              gate;
  logic              locked;
  logic              full;
  logic [OCC_W-1:0]  occ;
`ifdef PARKING_GATE_ALARM_EN
  logic              alarm;

  modport master (output car, fr_sens, bk_sens, ex_sens, pswd, pswd_vld,
                  input  gate, locked, full, occ, alarm);
  modport slave  (input  car, fr_sens, bk_sens, ex_sens, pswd, pswd_vld,
                  output gate, locked, full, occ, alarm);
`else
  modport master (output car, fr_sens, bk_sens, ex_sens, pswd, pswd_vld,
                  input  gate, locked, full, occ);
  modport slave  (input  car, fr_sens, bk_sens, ex_sens, pswd, pswd_vld,
                  output gate, locked, full, occ);
`endif

endinterface

// File: rtl/parking_occ_counter.sv
// parking_occ_counter: saturating up/down lot occupancy counter.
//   clk, rst : clock, synchronous active-high reset
//   inc, dec : one car in / one car out this cycle (both together cancel)
//   occ      : registered occupancy, saturates at 0 and CAPACITY
//   full     : occ == CAPACITY, decoded from the register
module parking_occ_counter
  import parking_gate_pkg::*;
#(
  parameter  int CAPACITY = DEF_CAPACITY,
  localparam int OCC_W    = cnt_width(CAPACITY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [OCC_W-1:0] occ,
  output logic             full
);

  localparam logic [OCC_W-1:0] CAP_V = OCC_W'(CAPACITY);

  logic [OCC_W-1:0] occ_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else if (inc && !dec && (occ_q != CAP_V)) begin
      occ_q <= occ_q + 1'b1;
    end else if (dec && !inc && (occ_q != '0)) begin
      occ_q <= occ_q - 1'b1;
    end
  end

  assign occ  = occ_q;
  assign full = (occ_q == CAP_V);

endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: single entry-lane barrier controller with keypad, lockout
// and lot occupancy tracking.
//   clk, rst : clock, synchronous active-high reset
//   bus      : parking_gate_if.slave (sensors/keypad in; gate, locked, full, occ out)
// Optional: define PARKING_GATE_ALARM_EN to add bus.alarm (high while locked,
// one-cycle pulse after each open timeout).
//
// state    | meaning
// IDLE     | barrier closed, waiting for a car at the front sensor
// WAIT_KEY | car present, waiting for the keypad value
// OPEN     | barrier open until back sensor or timeout
// LOCKED   | too many wrong keys, inputs ignored for LOCK_CYCLES clocks
module parking_gate_ctrl
  import parking_gate_pkg::*;
#(
  parameter int PSWD_W       = DEF_PSWD_W,
  parameter int PSWD_VAL     = DEF_PSWD_VAL,
  parameter int MAX_TRIES    = DEF_MAX_TRIES,
  parameter int LOCK_CYCLES  = DEF_LOCK_CYCLES,
  parameter int OPEN_TIMEOUT = DEF_OPEN_TIMEOUT,
  parameter int CAPACITY     = DEF_CAPACITY
) (
  input  logic           clk,
  input  logic           rst,
  parking_gate_if.slave  bus
);

  localparam int TRY_W = cnt_width(MAX_TRIES);
  localparam int TMR_W = cnt_width(OPEN_TIMEOUT);
  localparam int LCK_W = cnt_width(LOCK_CYCLES);
  localparam int OCC_W = cnt_width(CAPACITY);

  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(OPEN_TIMEOUT - 1);
  localparam logic [LCK_W-1:0] LCK_LAST = LCK_W'(LOCK_CYCLES - 1);
  localparam logic [PSWD_W-1:0] KEY    = PSWD_W'(PSWD_VAL);

  state_e           state_q;
  logic [TRY_W-1:0] tries_q;
  logic [TMR_W-1:0] tmr_q;
  logic [LCK_W-1:0] lck_q;
  logic             gate_q;
  logic             locked_q;

  logic             full;
  logic [OCC_W-1:0] occ;

  // Decoded events shared by the FSM and the optional alarm register.
  logic key_ok, key_bad_last, pass, tmo_hit, lck_done;

  assign key_ok       = (state_q == WAIT_KEY) && bus.car && bus.pswd_vld && (bus.pswd == KEY);
  assign key_bad_last = (state_q == WAIT_KEY) && bus.car && bus.pswd_vld && (bus.pswd != KEY)
                        && (tries_q == TRY_LAST);
  assign pass         = (state_q == OPEN) && bus.bk_sens;
  assign tmo_hit      = (state_q == OPEN) && !bus.bk_sens && (tmr_q == TMR_LAST);
  assign lck_done     = (state_q == LOCKED) && (lck_q == LCK_LAST);

  // gate/locked are written alongside every state change so they stay
  // registered copies of the state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tries_q  <= '0;
      tmr_q    <= '0;
      lck_q    <= '0;
      gate_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.car && bus.fr_sens && !full) state_q <= WAIT_KEY;
        end
        WAIT_KEY: begin
          if (!bus.car) begin
            state_q <= IDLE;
            tries_q <= '0;
          end else if (key_ok) begin
            state_q <= OPEN;
            gate_q  <= 1'b1;
            tries_q <= '0;
            tmr_q   <= '0;
          end else if (key_bad_last) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
            tries_q  <= tries_q + 1'b1;
            lck_q    <= '0;
          end else if (bus.pswd_vld) begin
            tries_q <= tries_q + 1'b1;
          end
        end
        OPEN: begin
          if (pass || tmo_hit) begin
            state_q <= IDLE;
            gate_q  <= 1'b0;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        LOCKED: begin
          if (lck_done) begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
            tries_q  <= '0;
          end else begin
            lck_q <= lck_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset dominates inside the counter, so a pass on the reset edge is dropped.
  parking_occ_counter #(.CAPACITY(CAPACITY)) u_occ (
    .clk  (clk),
    .rst  (rst),
    .inc  (pass),
    .dec  (bus.ex_sens),
    .occ  (occ),
    .full (full)
  );

  assign bus.gate   = gate_q;
  assign bus.locked = locked_q;
  assign bus.full   = full;
  assign bus.occ    = occ;

`ifdef PARKING_GATE_ALARM_EN
  logic alarm_q;

  // High for the whole lockout, plus one cycle after an abandoned opening.
  always_ff @(posedge clk) begin
    if (rst) alarm_q <= 1'b0;
    else     alarm_q <= key_bad_last || ((state_q == LOCKED) && !lck_done) || tmo_hit;
  end

  assign bus.alarm = alarm_q;
`endif

endmodule
